// File: rtl/mem_dump_uart_tx.sv
// ---------------------------------------------------------------------------
// mem_dump_uart_tx
//
// Purpose:
//   Walks a synchronous-read BRAM from a first to a last word address
//   (wrapping mod 256) and streams every 16-bit word out of a UART
//   transmitter as two 8N1 frames, low byte first, each byte LSB first.
//   The two frames of a word are back to back; consecutive words are
//   separated by exactly two idle-high cycles (BRAM fetch + latch).
//
// Parameters:
//   CLK_FREQ      i_clk frequency in Hz
//   BAUD          serial bit rate; CLK_FREQ/BAUD (cycles per bit) must be >= 4
//
// Ports:
//   i_clk         sole clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_start       single-cycle dump request (ignored while busy or on o_done)
//   i_addr_first  first word address, sampled with i_start
//   i_addr_last   last word address, sampled with i_start
//   o_addr_read   BRAM read address
//   i_data_read   BRAM read data, valid one cycle after o_addr_read changes
//   o_tx          UART line, idle high, driven from a flop
//   o_busy        high from the accepting edge until the o_done edge
//   o_done        one-cycle pulse when the last word's stop bit ends
//
// States:
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_IDLE  | waiting for i_start, line idle high
//   S_FETCH | o_addr_read presented, waiting one cycle of BRAM latency
//   S_LATCH | read data captured into the shift register, start bit begins
//   S_START | start bit on the line (low) for one bit time
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); then next byte, next word, or done
// ---------------------------------------------------------------------------
module mem_dump_uart_tx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 115200
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_addr_first,
  input  logic [7:0]  i_addr_last,
  output logic [7:0]  o_addr_read,
  input  logic [15:0] i_data_read,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done
);

  localparam int CPB   = CLK_FREQ / BAUD;
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  // The baud timer is a down-counter: loaded with CPB-1 at each bit
  // boundary, the bit ends on the edge where it is seen at zero.
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t            state;
  logic [7:0]        addr_last;
  logic [15:0]       shift_reg;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic              byte_idx;
  logic              bit_end;

  assign bit_end = (baud_cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      addr_last   <= '0;
      o_addr_read <= '0;
      shift_reg   <= '0;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      byte_idx    <= 1'b0;
      o_tx        <= 1'b1;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          // o_done is high in the cycle right after a dump finishes; a
          // request landing there belongs to the old dump and is dropped.
          if (i_start && !o_done) begin
            addr_last   <= i_addr_last;
            o_addr_read <= i_addr_first;
            o_busy      <= 1'b1;
            state       <= S_FETCH;
          end
        end

        S_FETCH: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          shift_reg <= i_data_read;
          o_tx      <= 1'b0;
          byte_idx  <= 1'b0;
          baud_cnt  <= BIT_LOAD;
          state     <= S_START;
        end

        S_START: begin
          if (bit_end) begin
            o_tx     <= shift_reg[0];
            bit_idx  <= '0;
            baud_cnt <= BIT_LOAD;
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= BIT_LOAD;
            // Shifting once per data bit, including the last one, leaves
            // the high byte in shift_reg[7:0] after the low byte is sent.
            shift_reg <= {1'b0, shift_reg[15:1]};
            if (bit_idx == 3'd7) begin
              o_tx  <= 1'b1;
              state <= S_STOP;
            end else begin
              o_tx    <= shift_reg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (!byte_idx) begin
              // High byte's start bit follows the low byte's stop bit
              // with no idle gap.
              o_tx     <= 1'b0;
              byte_idx <= 1'b1;
              baud_cnt <= BIT_LOAD;
              state    <= S_START;
            end else if (o_addr_read == addr_last) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              o_addr_read <= o_addr_read + 8'd1;
              state       <= S_FETCH;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_uart_tx.sv
module tb_mem_dump_uart_tx;

  localparam int CPB      = 10;
  localparam int WORD_CYC = 20 * CPB + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  addr_first = 8'h00;
  logic [7:0]  addr_last = 8'h00;
  logic [7:0]  addr_read;
  logic [15:0] data_read;
  logic        tx;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;

  logic [15:0] mem [256];
  logic [7:0]  exp_q [$];

  typedef struct {
    logic [7:0] first;
    logic [7:0] last;
    int         n_words;
  } vec_t;

  vec_t vecs [5];

  mem_dump_uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (100)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_addr_first(addr_first),
    .i_addr_last (addr_last),
    .o_addr_read (addr_read),
    .i_data_read (data_read),
    .o_tx        (tx),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read BRAM model and cycle counter.
  always @(posedge clk) begin
    data_read <= mem[addr_read];
    cyc       <= cyc + 1;
  end

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // UART monitor: every bit is sampled CPB times; the centre sample is
  // the bit value and all samples of a bit must agree (width check).
  logic [9:0] mon_bits;
  logic       mon_first;
  bit         mon_abort;
  bit         mon_bad;

  initial begin : uart_mon
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        mon_abort = 1'b0;
        mon_bad   = 1'b0;
        mon_bits  = '0;
        for (int b = 0; b < 10 && !mon_abort; b++) begin
          for (int s = 0; s < CPB && !mon_abort; s++) begin
            if (b != 0 || s != 0) @(negedge clk);
            if (rst) begin
              mon_abort = 1'b1;
            end else begin
              if (s == CPB / 2) mon_bits[b] = tx;
              if (s == 0) mon_first = tx;
              else if (tx !== mon_first) mon_bad = 1'b1;
            end
          end
        end
        if (!mon_abort) begin
          check("bit_width", int'(mon_bad), 0);
          check("stop_bit", int'(mon_bits[9]), 1);
          check("byte_expected", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            check("rx_byte", int'(mon_bits[8:1]), int'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  task automatic push_expected(input logic [7:0] f, input logic [7:0] l);
    logic [7:0] span;
    logic [7:0] a;
    span = l - f;
    a    = f;
    for (int i = 0; i <= int'(span); i++) begin
      exp_q.push_back(mem[a][7:0]);
      exp_q.push_back(mem[a][15:8]);
      a = a + 8'd1;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic kick(input logic [7:0] f, input logic [7:0] l, output int e0);
    addr_first = f;
    addr_last  = l;
    start      = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk);
    start      = 1'b0;
    addr_first = ~f;
    addr_last  = ~l;
  endtask

  task automatic run_dump(input logic [7:0] f, input logic [7:0] l, input int n_words,
                          input bit poke_mid, input bit poke_done, input bit no_align);
    int         e0;
    int         d_edge;
    int         done0;
    int         addr_seen;
    logic [7:0] last_addr;
    logic [7:0] ea;
    bit         got_done;
    bit         tx_bad;
    bit         busy_bad;
    push_expected(f, l);
    done0 = done_cnt;
    if (!no_align) @(negedge clk);
    kick(f, l, e0);
    check("busy_after_start", int'(busy), 1);
    check("addr_first", int'(addr_read), int'(f));
    check("tx_high_e0", int'(tx), 1);
    @(negedge clk);
    check("tx_high_fetch", int'(tx), 1);
    @(negedge clk);
    check("start_bit_e0p2", int'(tx), 0);
    last_addr = f;
    addr_seen = 1;
    got_done  = 1'b0;
    d_edge    = 0;
    for (int k = 0; k < n_words * WORD_CYC + 50 && !got_done; k++) begin
      @(negedge clk);
      if (addr_read !== last_addr) begin
        ea = f + 8'(addr_seen);
        check("addr_seq", int'(addr_read), int'(ea));
        last_addr = addr_read;
        addr_seen++;
      end
      if (poke_mid) begin
        start      = (((cyc - e0) % 150) == 73) ? 1'b1 : 1'b0;
        addr_first = 8'h33;
        addr_last  = 8'h44;
      end
      if (done === 1'b1) begin
        got_done = 1'b1;
        d_edge   = cyc;
        if (poke_done) start = 1'b1;
      end
    end
    check("done_seen", int'(got_done), 1);
    check("done_time", d_edge - e0, n_words * WORD_CYC);
    check("addr_count", addr_seen, n_words);
    @(negedge clk);
    start    = 1'b0;
    tx_bad   = 1'b0;
    busy_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tx !== 1'b1) tx_bad = 1'b1;
      if (busy !== 1'b0) busy_bad = 1'b1;
      @(negedge clk);
    end
    check("tx_idle_after_done", int'(tx_bad), 0);
    check("busy_low_after_done", int'(busy_bad), 0);
    check("done_pulses", done_cnt - done0, 1);
    check("bytes_pending", exp_q.size(), 0);
  endtask

  initial begin
    int e0;
    int done0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = {8'(i) ^ 8'h5A, ~8'(i)};
    end
    mem[8'h05] = 16'hA53C;
    mem[8'h10] = 16'h1234;
    mem[8'h11] = 16'h5678;
    mem[8'h12] = 16'h9ABC;
    mem[8'h20] = 16'hC3E1;

    vecs[0] = '{8'h05, 8'h05, 1};
    vecs[1] = '{8'h10, 8'h12, 3};
    vecs[2] = '{8'hFE, 8'h01, 4};
    vecs[3] = '{8'hFF, 8'hFF, 1};
    vecs[4] = '{8'h80, 8'h84, 5};

    repeat (3) @(negedge clk);
    check("rst_tx", int'(tx), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_addr", int'(addr_read), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].first, vecs[v].last, vecs[v].n_words, 1'b0, 1'b0, 1'b0);
    end

    // Requests during busy and on the o_done cycle must be ignored.
    run_dump(8'h10, 8'h12, 3, 1'b1, 1'b1, 1'b0);

    // Reset during data bit 4 of the high byte of the first word.
    exp_q.push_back(mem[8'h20][7:0]);
    done0 = done_cnt;
    @(negedge clk);
    kick(8'h20, 8'h22, e0);
    do begin
      @(posedge clk);
      #1;
    end while (cyc < e0 + 155);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_tx", int'(tx), 1);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_done", int'(done), 0);
    check("rst_mid_addr", int'(addr_read), 0);
    repeat (3) @(negedge clk);
    check("rst_mid_no_done", done_cnt - done0, 0);
    check("rst_mid_low_byte_rx", exp_q.size(), 0);
    exp_q.delete();
    rst = 1'b0;
    run_dump(8'h05, 8'h06, 2, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
